seg7_scan_scheduler: RTL
========================

Name: seg7_scan_scheduler

Overview:
Time-multiplexed scan controller for the stopwatch's common-anode 7-segment display. It replaces the free-running 2-bit refresh counter with a prescaled, fixed-rate digit scheduler. The scheduler inserts guard (blank) time between digits to suppress ghosting and captures display data atomically at frame boundaries through a load/ack handshake. It also performs hex-to-segment decoding, per-digit masking and leading-zero blanking. It sits between the stopwatch BCD counters and the board anode/segment pins.

Parameters:
N_DIGITS, 3, number of digits scanned, legal range 1..8
PRESCALE, 1000, clock cycles per digit slot, must be >= GUARD+1
GUARD, 100, blank cycles at the start of each slot, must be >= 0
IDX_W, 2, width of the digit index, equal to max(1, clog2(N_DIGITS))

Ports:
i_clk  in  1  system clock
i_rst  in  1  reset, synchronous, active-high
i_bcd  in  4*N_DIGITS  digit values; digit k is i_bcd[4k+3:4k], digit 0 is least significant
i_dp  in  N_DIGITS  decimal point per digit, 1 = lit
i_digit_mask  in  N_DIGITS  1 = digit enabled, 0 = digit always blank
i_lz_blank  in  1  1 = leading-zero blanking enabled
i_load  in  1  level request to capture i_bcd/i_dp; hold high until o_load_ack
o_load_ack  out  1  one-cycle pulse when capture happens
o_digit_sel_n  out  N_DIGITS  anode enables, active-low, at most one low
o_seg_n  out  8  segments, active-low, {dp,g,f,e,d,c,b,a}
o_digit_idx  out  IDX_W  current slot index
o_frame_start  out  1  one-cycle pulse in the first cycle of slot 0

Behaviour:
- Reset state (i_rst=1 at an edge): s_cnt=0, idx=0, shadow bcd=0, shadow dp=0. Outputs: o_digit_sel_n all 1, o_seg_n=8'hFF, o_load_ack=0, o_frame_start=0, o_digit_idx=0.
- Reset has priority over every other event and may occur mid-slot; the next cycle is fully blank.
- Slot counter: s_cnt increments every cycle.
  - At s_cnt==PRESCALE-1, s_cnt goes to 0 and idx advances.
  - idx wraps from N_DIGITS-1 to 0.
- Frame period is always N_DIGITS*PRESCALE cycles; masking never shortens it.
- Slot phases, per slot:
  - GUARD: s_cnt < GUARD; all anodes high, o_seg_n=8'hFF.
  - DRIVE: s_cnt >= GUARD; the digit is driven when shown, otherwise treated as GUARD.
- All outputs are registered and aligned to the state: in a cycle with state (s_cnt, idx), the outputs reflect that state. The implementation computes them from next-state.
- A digit is shown in DRIVE when both hold:
  - i_digit_mask[idx]=1 (mask is sampled live, not shadowed).
  - It is not leading-zero blanked.
- When shown: o_digit_sel_n[idx]=0, o_seg_n[6:0]=hex decode of shadow[idx], o_seg_n[7]=~shadow_dp[idx].
- Leading-zero blanking, when i_lz_blank=1:
  - Digit k>0 is blanked if shadow digits N_DIGITS-1..k are all 0.
  - Digit 0 is never blanked by this rule.
  - Uses shadow values only; the mask does not affect the rule.
- Decode, active-low: 0=C0 1=F9 2=A4 3=B0 4=99 5=92 6=82 7=F8 8=80 9=90 A=88 b=83 C=C6 d=A1 E=86 F=8E, giving bits [6:0]. Bit 7 comes from dp.
- Load handshake, captured on the edge where idx wraps N_DIGITS-1 to 0:
  - If i_load=1 on that edge: shadow <= i_bcd/i_dp, and o_load_ack=1 for exactly that following cycle, coincident with o_frame_start.
  - If i_load=0: the shadow is unchanged.
  - i_load deasserted before ack means the request is dropped; this is legal.
  - The new shadow is visible from slot 0 of the new frame.
- o_frame_start is asserted in the cycle s_cnt=0, idx=0, except the first cycle after reset.
- N_DIGITS=1: idx stays 0, every slot is a frame, and loads can occur every PRESCALE cycles.

Test Plan:
Use N_DIGITS=3, PRESCALE=8, GUARD=2 for all scenarios.
1. Reset: hold i_rst 3 cycles mid-operation -> next cycle o_seg_n=FF, o_digit_sel_n=111, ack=0. First o_frame_start comes 24 cycles after release, then every 24 cycles.
2. Load: i_bcd=12'h123, mask=111, lz=0, i_load high until ack -> ack pulses with frame_start. Then per slot, s_cnt 0-1 blank, s_cnt 2-7 driven:
   - slot0: sel=110, seg=B0
   - slot1: sel=101, seg=A4
   - slot2: sel=011, seg=F9
3. LZB: load 12'h005, lz=1 -> slots 2 and 1 blank, slot0 seg=92. Load 12'h000 -> slot0 seg=C0. Load 12'h050 -> slot1 seg=92, slot0 seg=C0.
4. Mask: mask=101 with 12'h123 -> slot1 is never driven, frame period stays 24 cycles. Changing mask mid-frame takes effect in the next cycle.
5. Atomic capture: i_load raised at idx=1, and i_bcd changed 123->456->789 before the wrap -> the display shows 123 until the wrap, then 789. Ack is a single pulse.
6. DP/hex: i_bcd=12'hF0A, i_dp=3'b010 -> seg: slot0=88, slot1=40, slot2=8E.

Source files
------------

// File: rtl/seg7_scan_if.sv
// Signal bundle between the stopwatch counters (master) and the 7-segment
// scan scheduler (slave): display data, load handshake and pin drives.
interface seg7_scan_if #(
    parameter int N_DIGITS = 3,
    parameter int IDX_W    = 2
);
    logic [4*N_DIGITS-1:0] i_bcd;
    logic [N_DIGITS-1:0]   i_dp;
    logic [N_DIGITS-1:0]   i_digit_mask;
    logic                  i_lz_blank;
    logic                  i_load;
    logic                  o_load_ack;
    logic [N_DIGITS-1:0]   o_digit_sel_n;
    logic [7:0]            o_seg_n;
    logic [IDX_W-1:0]      o_digit_idx;
    logic                  o_frame_start;

    modport master (
        output i_bcd, i_dp, i_digit_mask, i_lz_blank, i_load,
        input  o_load_ack, o_digit_sel_n, o_seg_n, o_digit_idx, o_frame_start
    );

    modport slave (
        input  i_bcd, i_dp, i_digit_mask, i_lz_blank, i_load,
        output o_load_ack, o_digit_sel_n, o_seg_n, o_digit_idx, o_frame_start
    );
endinterface

// File: rtl/seg7_scan_scheduler.sv
// Prescaled fixed-rate digit scanner for a common-anode 7-segment display,
// with guard blanking, frame-atomic data capture, masking and zero blanking.
module seg7_scan_scheduler #(
    parameter int N_DIGITS = 3,
    parameter int PRESCALE = 1000,
    parameter int GUARD    = 100,
    parameter int IDX_W    = 2
) (
    input  logic          i_clk,
    input  logic          i_rst,
    seg7_scan_if.slave    bus
);
    localparam int CNT_W = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(PRESCALE - 1);
    localparam logic [CNT_W-1:0] CNT_GUARD = CNT_W'(GUARD);
    localparam logic [IDX_W-1:0] IDX_LAST  = IDX_W'(N_DIGITS - 1);

    logic [CNT_W-1:0]      s_cnt_q, s_cnt_d;
    logic [IDX_W-1:0]      idx_q, idx_d;
    logic [4*N_DIGITS-1:0] bcd_q, bcd_d;
    logic [N_DIGITS-1:0]   dp_q, dp_d;
    logic [N_DIGITS-1:0]   sel_q, sel_d;
    logic [7:0]            seg_q, seg_d;
    logic                  ack_q, ack_d;
    logic                  fs_q, fs_d;
    logic                  capture;

    function automatic logic [6:0] hex_to_seg(input logic [3:0] v);
        case (v)
            4'h0:    hex_to_seg = 7'h40;
            4'h1:    hex_to_seg = 7'h79;
            4'h2:    hex_to_seg = 7'h24;
            4'h3:    hex_to_seg = 7'h30;
            4'h4:    hex_to_seg = 7'h19;
            4'h5:    hex_to_seg = 7'h12;
            4'h6:    hex_to_seg = 7'h02;
            4'h7:    hex_to_seg = 7'h78;
            4'h8:    hex_to_seg = 7'h00;
            4'h9:    hex_to_seg = 7'h10;
            4'hA:    hex_to_seg = 7'h08;
            4'hB:    hex_to_seg = 7'h03;
            4'hC:    hex_to_seg = 7'h46;
            4'hD:    hex_to_seg = 7'h21;
            4'hE:    hex_to_seg = 7'h06;
            default: hex_to_seg = 7'h0E;
        endcase
    endfunction

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            s_cnt_q <= '0;
            idx_q   <= '0;
            bcd_q   <= '0;
            dp_q    <= '0;
            sel_q   <= '1;
            seg_q   <= 8'hFF;
            ack_q   <= 1'b0;
            fs_q    <= 1'b0;
        end else begin
            s_cnt_q <= s_cnt_d;
            idx_q   <= idx_d;
            bcd_q   <= bcd_d;
            dp_q    <= dp_d;
            sel_q   <= sel_d;
            seg_q   <= seg_d;
            ack_q   <= ack_d;
            fs_q    <= fs_d;
        end
    end

    always_comb begin
        s_cnt_d = s_cnt_q + 1'b1;
        idx_d   = idx_q;
        capture = 1'b0;
        if (s_cnt_q == CNT_LAST) begin
            s_cnt_d = '0;
            if (idx_q == IDX_LAST) begin
                idx_d   = '0;
                capture = bus.i_load;
            end else begin
                idx_d = idx_q + 1'b1;
            end
        end
        bcd_d = capture ? bus.i_bcd : bcd_q;
        dp_d  = capture ? bus.i_dp  : dp_q;
    end

    // Outputs are derived from next-state so the registered pins line up
    // with the (s_cnt, idx) state of the same cycle.
    always_comb begin
        logic                zero_run;
        logic                lz_hit;
        logic                en;
        logic                dp_bit;
        logic [3:0]          digit;
        logic [N_DIGITS-1:0] onehot;
        zero_run = 1'b1;
        lz_hit   = 1'b0;
        en       = 1'b0;
        dp_bit   = 1'b0;
        digit    = '0;
        onehot   = '0;
        for (int k = N_DIGITS - 1; k >= 0; k--) begin
            zero_run = zero_run && (bcd_d[4*k +: 4] == 4'd0);
            if (idx_d == IDX_W'(k)) begin
                onehot[k] = 1'b1;
                digit     = bcd_d[4*k +: 4];
                dp_bit    = dp_d[k];
                en        = bus.i_digit_mask[k];
                lz_hit    = bus.i_lz_blank && (k != 0) && zero_run;
            end
        end
        sel_d = '1;
        seg_d = 8'hFF;
        if ((s_cnt_d >= CNT_GUARD) && en && !lz_hit) begin
            sel_d = ~onehot;
            seg_d = {~dp_bit, hex_to_seg(digit)};
        end
        ack_d = capture;
        fs_d  = (s_cnt_d == '0) && (idx_d == '0);
    end

    assign bus.o_digit_sel_n = sel_q;
    assign bus.o_seg_n       = seg_q;
    assign bus.o_load_ack    = ack_q;
    assign bus.o_frame_start = fs_q;
    assign bus.o_digit_idx   = idx_q;
endmodule
